cpu_run_ctrl: RTL

- Board-level run/clock controller for the pipelined CPU. It replaces the gated-clock mux with a single-clock enable scheme.
- Synchronises and debounces the run/reset/speed/step switches and generates a one-cycle CPU clock-enable at one of four selectable rates.
- Sequences run, pause, single-step, halt and soft-reset for the CPU core and display logic.

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/sw_debounce.sv | 45 ++++
 rtl/cpu_run_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/clock controller: run-state encoding,
// speed shift table and the tick-period helper.
package cpu_ctrl_pkg;

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_PAUSE = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  typedef enum logic [2:0] {
    ST_RESET = S_RESET,
    ST_PAUSE = S_PAUSE,
    ST_RUN   = S_RUN,
    ST_STEP  = S_STEP,
    ST_HALT  = S_HALT
  } run_state_e;

  localparam int unsigned TICK_W = 32;

  // Right-shift applied to DIV for speed index 0..3
  localparam logic [3:0][2:0] SPEED_SHIFT = {3'd4, 3'd2, 3'd1, 3'd0};

  // Tick period for a speed index, never below one cycle
  function automatic logic [TICK_W-1:0] speed_period(input logic [TICK_W-1:0] div,
                                                     input logic [1:0]        sel);
    logic [TICK_W-1:0] p;
    p = div >> SPEED_SHIFT[sel];
    return (p == '0) ? TICK_W'(1) : p;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debouncer for one raw switch; level follows the
// synchronised input once it has differed for DEB_CYCLES consecutive cycles.
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      rise <= 1'b0;
      if (r_s2 != level) begin
        if (r_cnt == CNT_LAST) begin
          level <= r_s2;
          rise  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/clock controller: conditions the board switches and sequences the CPU
// through reset, run, pause, single-step and halt using a one-cycle clock enable.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV        = 10_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_go,
  input  logic             sw_rst,
  input  logic             sw_speed,
  input  logic             btn_step,
  input  logic             cpu_halt,
  output logic             cpu_ce,
  output logic             cpu_rst,
  output logic [1:0]       speed_sel,
  output logic [2:0]       run_state,
  output logic [CNT_W-1:0] ce_count
);

  logic w_go, w_go_rise;
  logic w_rst_sw, w_rst_rise;
  logic w_speed_lvl, w_speed_rise;
  logic w_step_lvl, w_step_rise;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_go (
    .clk(clk), .rst_n(rst_n), .raw(sw_go), .level(w_go), .rise(w_go_rise));
  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk(clk), .rst_n(rst_n), .raw(sw_rst), .level(w_rst_sw), .rise(w_rst_rise));
  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
    .clk(clk), .rst_n(rst_n), .raw(sw_speed), .level(w_speed_lvl), .rise(w_speed_rise));
  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk(clk), .rst_n(rst_n), .raw(btn_step), .level(w_step_lvl), .rise(w_step_rise));

  // Debouncer outputs this controller has no use for
  logic w_unused_deb;
  assign w_unused_deb = &{1'b0, w_go_rise, w_rst_rise, w_speed_lvl, w_step_lvl};

  run_state_e        r_state;
  logic [TICK_W-1:0] r_tcnt;
  logic [TICK_W-1:0] w_period;
  logic              w_tick;

  assign w_period  = speed_period(TICK_W'(DIV), speed_sel);
  assign w_tick    = (r_state == ST_RUN) && (r_tcnt == (w_period - TICK_W'(1)));
  assign run_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET;
      r_tcnt    <= '0;
      cpu_ce    <= 1'b0;
      cpu_rst   <= 1'b1;
      speed_sel <= 2'd0;
      ce_count  <= '0;
    end else begin
      if (w_speed_rise) begin
        speed_sel <= speed_sel + 2'd1;
      end

      // Tick counter only advances while running; a speed change restarts it
      if (w_speed_rise || (r_state != ST_RUN) || w_tick) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + TICK_W'(1);
      end

      if (r_state == ST_RESET) begin
        ce_count <= '0;
      end else if (cpu_ce) begin
        ce_count <= ce_count + CNT_W'(1);
      end

      cpu_ce  <= 1'b0;
      cpu_rst <= 1'b0;
      if (w_rst_sw) begin
        r_state <= ST_RESET;
        cpu_rst <= 1'b1;
      end else begin
        case (r_state)
          ST_RESET: r_state <= w_go ? ST_RUN : ST_PAUSE;
          ST_RUN: begin
            if (cpu_halt) begin
              r_state <= ST_HALT;
            end else begin
              cpu_ce <= w_tick;
              if (!w_go) r_state <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (w_go) begin
              r_state <= ST_RUN;
            end else if (w_step_rise) begin
              r_state <= ST_STEP;
              cpu_ce  <= 1'b1;
            end
          end
          ST_STEP:  r_state <= w_go ? ST_RUN : ST_PAUSE;
          ST_HALT:  r_state <= ST_HALT;
          default:  r_state <= ST_RESET;
        endcase
      end
    end
  end

endmodule
